// File: rtl/uart_rx_framer.sv
// uart_rx_framer -- UART receive framer, 16x oversampled, single clock domain.
//
// Recovers 8N1 frames from the asynchronous serial line and writes each good
// byte into the receive FIFO write port. Defining UART_RX_PARITY_EN switches
// the frame format to 8E1: an even parity bit sits between data bit 7 and the
// stop bit.
//
// Parameters
//   CLK_FREQ  clock frequency, Hz
//   BAUD      line rate, bit/s
//   OSR       oversample ratio; DIV = CLK_FREQ/(BAUD*OSR), truncated
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   uart_rxd   serial input, idle high, asynchronous to clk
//   fifo_full  receive FIFO full flag, looked at only on the write cycle
//   rf_data    last received byte; updated only when a byte is written
//   fr_wrreq   one-clk write strobe into the receive FIFO
//   frame_err  one-clk pulse when the stop bit is sampled low
//   overrun    one-clk pulse when a good byte is dropped because the FIFO is full
//   par_err    one-clk pulse on a parity mismatch (always 0 without UART_RX_PARITY_EN)
module uart_rx_framer #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OSR      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       fifo_full,
  output logic [7:0] rf_data,
  output logic       fr_wrreq,
  output logic       frame_err,
  output logic       overrun,
  output logic       par_err
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OSR);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           r_state;
  logic             r_rx_m, r_rxs, r_rxs_d;
  logic [DIV_W-1:0] r_div;
  logic [SMP_W-1:0] r_smp;
  logic             r_s7, r_s8;
  logic [7:0]       r_shift;
  logic [2:0]       r_bidx;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
`endif

  logic w_tick, w_dec, w_bit, w_edge;

  assign w_tick = (r_div == DIV_W'(DIV - 1));
  // Bit decision is made on the tick that ends sample 9; that tick's own
  // sample is the live synchronized value, 7 and 8 were captured earlier.
  assign w_dec  = w_tick && (r_smp == SMP_W'(9));
  assign w_bit  = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
  assign w_edge = r_rxs_d & ~r_rxs;

`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rx_m    <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
      r_div     <= '0;
      r_smp     <= '0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_shift   <= 8'h00;
      r_bidx    <= 3'd0;
      rf_data   <= 8'h00;
      fr_wrreq  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      fr_wrreq  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
      r_rx_m  <= uart_rxd;
      r_rxs   <= r_rx_m;
      r_rxs_d <= r_rxs;

      if (r_state == S_IDLE && w_edge) begin
        // Start edge re-phases the baud timing so sample 9 lands mid-bit.
        r_div   <= '0;
        r_smp   <= '0;
        r_state <= S_START;
      end else begin
        if (w_tick) begin
          r_div <= '0;
          r_smp <= (r_smp == SMP_W'(OSR - 1)) ? '0 : r_smp + 1'b1;
          if (r_smp == SMP_W'(7)) r_s7 <= r_rxs;
          if (r_smp == SMP_W'(8)) r_s8 <= r_rxs;
        end else begin
          r_div <= r_div + 1'b1;
        end

        case (r_state)
          S_START: if (w_dec) begin
            r_bidx  <= 3'd0;
            // A high decision means the edge was a glitch.
            r_state <= w_bit ? S_IDLE : S_DATA;
          end
          S_DATA: if (w_dec) begin
            r_shift <= {w_bit, r_shift[7:1]};
            if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bidx <= r_bidx + 3'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: if (w_dec) begin
            r_par   <= w_bit;
            r_state <= S_STOP;
          end
`endif
          S_STOP: if (w_dec) begin
            if (!w_bit) begin
              frame_err <= 1'b1;
              r_state   <= S_BREAK;
            end else begin
              // Back to IDLE at mid stop bit so an immediately following
              // start edge is not missed.
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{r_shift, r_par}) begin
                par_err <= 1'b1;
              end else
`endif
              if (fifo_full) begin
                overrun <= 1'b1;
              end else begin
                fr_wrreq <= 1'b1;
                rf_data  <= r_shift;
              end
            end
          end
          // Line held low after a framing error: wait for it to go idle.
          S_BREAK: if (r_rxs) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

  localparam int BIT = 160;  // clocks per bit: DIV=10, OSR=16
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;    // bit slots before the stop bit
`else
  localparam int NB = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] rf_data;
  logic       fr_wrreq, frame_err, overrun, par_err;

  uart_rx_framer #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OSR(16)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .fifo_full(fifo_full),
    .rf_data(rf_data), .fr_wrreq(fr_wrreq), .frame_err(frame_err),
    .overrun(overrun), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int n_wr = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  int wr_cyc = 0, st_cyc = 0;
  logic [7:0] got_q[$];

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (fr_wrreq) begin
      n_wr++;
      got_q.push_back(rf_data);
      wr_cyc = cyc;
    end
    if (frame_err) n_fe++;
    if (overrun)   n_ov++;
    if (par_err)   n_pe++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_fe = 0; n_ov = 0; n_pe = 0;
    got_q.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; rst_bit >= 0 pulses rst_n low inside that bit slot.
  task automatic send(input logic [7:0] b, input logic stopb, input logic parb,
                      input int rst_bit);
    logic [10:0] seq;
    int nbits;
    seq = '1;
    seq[0] = 1'b0;
    seq[8:1] = b;
`ifdef UART_RX_PARITY_EN
    seq[9] = parb;
    seq[10] = stopb;
    nbits = 11;
`else
    seq[9] = stopb;
    nbits = 10;
    if (parb) begin end
`endif
    @(negedge clk);
    st_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = seq[i];
      if (i == rst_bit) begin
        wait_clk(40); rst_n = 1'b0;
        wait_clk(8);  rst_n = 1'b1;
        wait_clk(BIT - 48 - 1);
      end else begin
        wait_clk(i == 0 ? BIT - 1 : BIT);
      end
      if (i == 0) @(negedge clk);
    end
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b1, ^b, -1);
    uart_rxd = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int wr, input int fe,
                              input int ov, input int pe, input logic [7:0] d);
    chk({tag, ".wr"}, n_wr, wr);
    chk({tag, ".fe"}, n_fe, fe);
    chk({tag, ".ov"}, n_ov, ov);
    chk({tag, ".pe"}, n_pe, pe);
    if (wr == 1) chk({tag, ".data"}, (got_q.size() > 0) ? int'(got_q[0]) : -1, int'(d));
    clr();
  endtask

  initial begin
    // Reset state
    wait_clk(3);
    chk("rst.rf_data", rf_data, 8'h00);
    chk("rst.wrreq", fr_wrreq, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.par_err", par_err, 0);
    rst_n = 1'b1;
    wait_clk(2 * BIT);
    clr();

    // 1: single 0x55, plus latency window
    good(8'h55);
    wait_clk(2 * BIT);
    chk("t1.lat_ok", ((wr_cyc - st_cyc) >= NB * BIT + 80 &&
                      (wr_cyc - st_cyc) <= NB * BIT + 130) ? 1 : 0, 1);
    expect_frame("t1", 1, 0, 0, 0, 8'h55);
    chk("t1.rf_hold", rf_data, 8'h55);

    // 2: back-to-back 0x00, 0xFF
    good(8'h00);
    good(8'hFF);
    wait_clk(2 * BIT);
    chk("t2.wr", n_wr, 2);
    chk("t2.d0", (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h00);
    chk("t2.d1", (got_q.size() > 1) ? int'(got_q[1]) : -1, 8'hFF);
    chk("t2.err", n_fe + n_ov + n_pe, 0);
    clr();

    // 3: short glitch rejected, then 0xA5
    uart_rxd = 1'b0; wait_clk(20); uart_rxd = 1'b1;
    wait_clk(2 * BIT);
    chk("t3.glitch", n_wr + n_fe + n_ov + n_pe, 0);
    good(8'hA5);
    wait_clk(2 * BIT);
    expect_frame("t3", 1, 0, 0, 0, 8'hA5);

    // 4: framing error with line held low, then resend
    send(8'h3C, 1'b0, ^8'h3C, -1);
    wait_clk(3 * BIT);
    uart_rxd = 1'b1;
    wait_clk(2 * BIT);
    expect_frame("t4.err", 0, 1, 0, 0, 8'h00);
    good(8'h3C);
    wait_clk(2 * BIT);
    expect_frame("t4.ok", 1, 0, 0, 0, 8'h3C);

    // 5: overrun with FIFO full, then resend
    fifo_full = 1'b1;
    good(8'h81);
    wait_clk(2 * BIT);
    expect_frame("t5.ovr", 0, 0, 1, 0, 8'h00);
    chk("t5.rf_hold", rf_data, 8'h3C);
    fifo_full = 1'b0;
    good(8'h81);
    wait_clk(2 * BIT);
    expect_frame("t5.ok", 1, 0, 0, 0, 8'h81);

    // Reset mid-frame (line high during bit slot 5 = data bit 4)
    send(8'hF0, 1'b1, ^8'hF0, 5);
    uart_rxd = 1'b1;
    wait_clk(2 * BIT);
    expect_frame("rstmid", 0, 0, 0, 0, 8'h00);
    chk("rstmid.rf", rf_data, 8'h00);
    good(8'h12);
    wait_clk(2 * BIT);
    expect_frame("rstmid.next", 1, 0, 0, 0, 8'h12);

`ifdef UART_RX_PARITY_EN
    // 6: parity good / bad
    send(8'h07, 1'b1, 1'b1, -1);
    uart_rxd = 1'b1;
    wait_clk(2 * BIT);
    expect_frame("t6.good", 1, 0, 0, 0, 8'h07);
    send(8'h07, 1'b1, 1'b0, -1);
    uart_rxd = 1'b1;
    wait_clk(2 * BIT);
    expect_frame("t6.bad", 0, 0, 0, 1, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
